// File: rtl/dmem_arbiter.sv
// Two-port arbiter for the single-port data memory: MEM stage (port 0) has priority,
// the loader/debug port (port 1) is guaranteed a slot after MAX_WAIT denied cycles.
module dmem_arbiter #(
  parameter int WIDTH    = 32,
  parameter int INDEX    = 5,
  parameter int MAX_WAIT = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             p0_req_in,
  input  logic             p0_we_in,
  input  logic [WIDTH-1:0] p0_addr_in,
  input  logic [WIDTH-1:0] p0_wdata_in,
  output logic             p0_gnt_out,
  output logic             p0_rvalid_out,
  output logic [WIDTH-1:0] p0_rdata_out,
  input  logic             p1_req_in,
  input  logic             p1_we_in,
  input  logic [WIDTH-1:0] p1_addr_in,
  input  logic [WIDTH-1:0] p1_wdata_in,
  output logic             p1_gnt_out,
  output logic             p1_rvalid_out,
  output logic [WIDTH-1:0] p1_rdata_out,
  output logic             stall_out,
  output logic             mem_we_out,
  output logic             mem_re_out,
  output logic [INDEX-1:0] mem_addr_out,
  output logic [WIDTH-1:0] mem_wdata_out,
  input  logic [WIDTH-1:0] mem_rdata_in
);

  localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

  logic [3:0] r_starve_cnt;
  logic       r_rd_pend;
  logic       r_rd_owner;

  logic       w_force_p1;
  logic       w_gnt0;
  logic       w_gnt1;
  logic       w_sel_we;
  logic [WIDTH-1:0] w_sel_addr;
  logic [WIDTH-1:0] w_sel_wdata;
  logic       w_unused_addr;

  // Combinational outputs are gated by reset so everything reads 0 while held in reset.
  assign w_force_p1 = p1_req_in && (r_starve_cnt == LP_MAX_WAIT);
  assign w_gnt0     = rst_n_in && p0_req_in && !w_force_p1;
  assign w_gnt1     = rst_n_in && p1_req_in && (!p0_req_in || w_force_p1);

  assign p0_gnt_out = w_gnt0;
  assign p1_gnt_out = w_gnt1;
  assign stall_out  = rst_n_in && p0_req_in && !w_gnt0;

  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    if (w_gnt0) begin
      w_sel_we    = p0_we_in;
      w_sel_addr  = p0_addr_in;
      w_sel_wdata = p0_wdata_in;
    end else if (w_gnt1) begin
      w_sel_we    = p1_we_in;
      w_sel_addr  = p1_addr_in;
      w_sel_wdata = p1_wdata_in;
    end
  end

  assign mem_we_out    = (w_gnt0 || w_gnt1) && w_sel_we;
  assign mem_re_out    = (w_gnt0 || w_gnt1) && !w_sel_we;
  assign mem_addr_out  = w_sel_addr[INDEX+1:2];
  assign mem_wdata_out = w_sel_wdata;

  // Byte offset and upper address bits are intentionally ignored (word access only).
  assign w_unused_addr = ^{w_sel_addr[1:0], w_sel_addr[WIDTH-1:INDEX+2]};

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_starve_cnt <= '0;
    end else if (!p1_req_in || w_gnt1) begin
      r_starve_cnt <= '0;
    end else if (r_starve_cnt != LP_MAX_WAIT) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      r_rd_pend <= mem_re_out;
      if (mem_re_out) begin
        r_rd_owner <= w_gnt1;
      end
    end
  end

  assign p0_rvalid_out = r_rd_pend && !r_rd_owner;
  assign p1_rvalid_out = r_rd_pend && r_rd_owner;
  assign p0_rdata_out  = p0_rvalid_out ? mem_rdata_in : '0;
  assign p1_rdata_out  = p1_rvalid_out ? mem_rdata_in : '0;

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port data memory between two requesters: port 0 is the pipeline MEM stage, and port 1 is the program loader/debug port.
- Port 0 has fixed priority. A starvation counter guarantees port 1 one slot after MAX_WAIT consecutive denied cycles.
- The block generates `stall_out` to hold the pipeline while the MEM stage is denied, and returns read data to the port that issued the read.
- It sits between the MEM stage and `dmem`, replacing the direct `dmem` connection.

Parameters:
- WIDTH, 32, data/address width.
- INDEX, 5, dmem word-index width; dmem address = addr[INDEX+1:2].
- MAX_WAIT, 4, denied cycles port 1 tolerates before forced grant (1..15).

Ports:
- clk_in  input  1  clock, rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- p0_req_in  input  1  MEM-stage access request.
- p0_we_in  input  1  1 = write, 0 = read.
- p0_addr_in  input  WIDTH  byte address.
- p0_wdata_in  input  WIDTH  write data.
- p0_gnt_out  output  1  access accepted this cycle.
- p0_rvalid_out  output  1  read data valid.
- p0_rdata_out  output  WIDTH  read data.
- p1_req_in, p1_we_in, p1_addr_in, p1_wdata_in, p1_gnt_out, p1_rvalid_out, p1_rdata_out: same as port 0, for the loader port.
- stall_out  output  1  p0_req_in & ~p0_gnt_out.
- mem_we_out  output  1  dmem write enable.
- mem_re_out  output  1  dmem read enable.
- mem_addr_out  output  INDEX  dmem word index.
- mem_wdata_out  output  WIDTH  dmem write data.
- mem_rdata_in  input  WIDTH  dmem read data, valid one cycle after mem_re_out.

Behaviour:
- Grant logic is combinational from the current requests and state. At most one of p0_gnt_out/p1_gnt_out is high per cycle.
- A granted request drives mem_* in the same cycle:
  - mem_we_out = we, mem_re_out = ~we.
  - mem_addr_out = addr[INDEX+1:2].
  - mem_wdata_out = wdata.
- With no grant, mem_we_out = mem_re_out = 0, and mem_addr_out/mem_wdata_out = 0.
- Priority rule: grant port 0 if p0_req_in, unless starve_cnt == MAX_WAIT and p1_req_in, in which case grant port 1. Otherwise, if only p1_req_in, grant port 1.
- Starvation counter (starve_cnt, 4 bits):
  - Increments each cycle p1_req_in is high and p1 is not granted; saturates at MAX_WAIT.
  - Clears to 0 on a p1 grant or when p1_req_in is low.
- Read return: a 1-bit registered "read owner" plus a "read pending" flag, captured on each granted read.
  - Next cycle: the owner's rvalid_out = 1 and its rdata_out = mem_rdata_in.
  - The non-owner's rvalid = 0 and its rdata = 0.
- Writes produce no rvalid.
- Back-to-back reads from either port are allowed every cycle; the return pipe is one entry deep.
- A requester keeps req/we/addr/wdata stable until it sees gnt. A request withdrawn before grant is dropped with no side effects.
- Simultaneous read by port 0 and write by port 1: only the granted access is performed. The other waits; no merging.
- Misaligned addresses: addr[1:0] is ignored (word access only).
- Reset (asynchronous, mid-operation included):
  - starve_cnt = 0, read pending = 0, owner = 0.
  - All outputs 0: gnt, rvalid, rdata, stall_out, and mem_* outputs.
  - A read granted in the cycle reset asserts returns no rvalid.
- Latency: grant 0 cycles; read data 1 cycle after grant.

Test Plan:
- Port 0 alone reads addr 0x0000_0010 (mem word 4 = 0xDEADBEEF):
  - Grant cycle: p0_gnt_out = 1, mem_addr_out = 4, mem_re_out = 1.
  - Next cycle: p0_rvalid_out = 1, p0_rdata_out = 0xDEADBEEF, p1_rvalid_out = 0.
- Port 1 alone writes 0x1234_5678 to addr 0x8 → p1_gnt_out = 1, mem_we_out = 1, mem_addr_out = 2, no rvalid. A later p0 read of 0x8 returns 0x12345678.
- Both ports request continuously with MAX_WAIT = 4:
  - Port 0 is granted for 4 cycles, port 1 in cycle 5 with stall_out = 1 that cycle, then port 0 again.
  - The pattern repeats with period 5.
- Port 0 read and port 1 read alternate every cycle → each rvalid is routed to the correct port, no cross-talk in rdata.
- Assert rst_n_in low in the cycle after a granted p0 read → p0_rvalid_out = 0 immediately, all outputs 0 while in reset, starve_cnt restarts at 0 after release.
- p1_req_in asserted for 3 denied cycles, deasserted 1 cycle, reasserted → counter restarts; forced grant only after 4 further denied cycles.
